buf_stream_writer: RTL

Write-side front end for the on-chip data buffer. It accepts a command (base address and word count) and a valid/ready data stream, then issues one registered write strobe per accepted word to the buffer's `cen`/`wen`/`addr`/`wdata` port. The address wraps at the buffer depth. A single-cycle `done` pulse fires once the last write has landed. It sits directly upstream of the buffer memory, between the DMA/feature stream and the storage array.

---
 rtl/buf_pkg.sv | 10 +
 rtl/buf_stream_writer_if.sv | 17 +
 rtl/buf_addr_gen.sv | 23 ++
 rtl/buf_stream_writer.sv | 81 ++++++++
 4 files changed

// File: rtl/buf_pkg.sv
// buf_pkg: state encoding, default widths and write-enable encoding for the buffer writer
package buf_pkg;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_LEN_WIDTH = 16;
    localparam logic WEN_WRITE = 1'b1;
    localparam logic WEN_READ = 1'b0;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
endpackage

// File: rtl/buf_stream_writer_if.sv
// buf_stream_writer_if: incoming data stream plus the buffer write port
interface buf_stream_writer_if
    import buf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic s_valid;
    logic s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic buf_cen;
    logic buf_wen;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_wdata;
    modport master(input s_valid, s_data, output s_ready, buf_cen, buf_wen, buf_addr, buf_wdata);
    modport slave(output s_valid, s_data, input s_ready, buf_cen, buf_wen, buf_addr, buf_wdata);
endinterface

// File: rtl/buf_addr_gen.sv
// buf_addr_gen: loadable address counter wrapping at DEPTH; out-of-range loads start at 0
module buf_addr_gen
    import buf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] addr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr <= '0;
        else if (load)
            addr <= (load_addr >= ADDR_WIDTH'(DEPTH)) ? '0 : load_addr;
        else if (inc)
            addr <= (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + 1'b1;
    end
endmodule

// File: rtl/buf_stream_writer.sv
// buf_stream_writer: command-driven stream-to-buffer writer; optional checksum via BUF_WR_CHECKSUM_EN
module buf_stream_writer
    import buf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
`ifdef BUF_WR_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    buf_stream_writer_if.master   bus
);
    state_t state;
    state_t state_nxt;
    logic [LEN_WIDTH-1:0] remaining;
    logic [ADDR_WIDTH-1:0] addr;
    logic accept;
    logic hs;
    logic last;
    assign accept = (state == IDLE) && start;
    assign hs = (state == LOAD) && bus.s_valid;
    assign last = hs && (remaining == LEN_WIDTH'(1));
    assign busy = state != IDLE;
    assign bus.s_ready = state == LOAD;
    // abort outranks a coinciding last handshake, so no done is produced
    always_comb begin
        state_nxt = accept ? ((len != '0) ? LOAD : DRAIN) :
                    ((state == LOAD) && abort) ? IDLE :
                    last ? DRAIN :
                    (state == DRAIN) ? IDLE : state;
    end
    buf_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_addr_gen (
        .clk(clk),
        .rst_n(rst_n),
        .load(accept),
        .load_addr(base_addr),
        .inc(hs),
        .addr(addr)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            remaining <= '0;
            done <= 1'b0;
            bus.buf_cen <= 1'b0;
            bus.buf_wen <= WEN_READ;
            bus.buf_addr <= '0;
            bus.buf_wdata <= '0;
        end else begin
            state <= state_nxt;
            remaining <= accept ? len : hs ? remaining - 1'b1 : remaining;
            done <= state == DRAIN;
            bus.buf_cen <= hs;
            bus.buf_wen <= hs ? WEN_WRITE : WEN_READ;
            if (hs) begin
                bus.buf_addr <= addr;
                bus.buf_wdata <= bus.s_data;
            end
        end
    end
`ifdef BUF_WR_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (hs)
            checksum <= checksum ^ bus.s_data;
    end
`endif
endmodule
